// File: rtl/pp_accumulator.sv
// rtl/pp_accumulator.sv - reduces four signed partial products into a 32-bit MAC result over N beats
// Optional macro: PP_ACC_SATURATE_EN (clamp result_o on 32-bit overflow instead of wrapping).
module pp_accumulator #(
    parameter int ACC_W = 42,
    parameter int LEN_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               normal_mul_i,
    input  logic               pp_valid_i,
    output logic               pp_ready_o,
    input  logic signed [33:0] partial_prods_i [4],
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [31:0]        result_o,
    output logic               ovf_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         count_q, count_d;
    logic                     normal_q, normal_d;
    logic signed [ACC_W-1:0]  beat_sum;
    logic                     beat;
    logic [ACC_W-32:0]        acc_hi;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            normal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            normal_q <= normal_d;
        end
    end

    // Products are sign-extended to ACC_W before summing so four 34-bit terms never lose carries.
    always_comb begin
        beat_sum = '0;
        if (normal_q) begin
            beat_sum = {{(ACC_W-34){partial_prods_i[0][33]}}, partial_prods_i[0]};
        end else begin
            for (int i = 0; i < 4; i++) begin
                beat_sum = beat_sum + {{(ACC_W-34){partial_prods_i[i][33]}}, partial_prods_i[i]};
            end
        end
    end

    assign beat = pp_valid_i && (state_q == S_ACCUM);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        normal_d = normal_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_ACCUM;
                    acc_d    = '0;
                    normal_d = normal_mul_i;
                    if (normal_mul_i || (len_i == '0)) begin
                        count_d = LEN_W'(1);
                    end else begin
                        count_d = len_i;
                    end
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d   = acc_q + beat_sum;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pp_ready_o  = (state_q == S_ACCUM);
        res_valid_o = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
    end

    // In-range iff bits [ACC_W-1:31] are all copies of the sign.
    assign acc_hi = acc_q[ACC_W-1:31];
    assign ovf_o  = !((&acc_hi) || (~|acc_hi));

    always_comb begin
        result_o = acc_q[31:0];
`ifdef PP_ACC_SATURATE_EN
        if (ovf_o) begin
            result_o = acc_q[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// tb/tb_pp_accumulator.sv - directed self-checking bench for pp_accumulator
module tb_pp_accumulator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         len;
    logic               normal_mul;
    logic               pp_valid;
    logic               pp_ready;
    logic signed [33:0] pp [4];
    logic               res_valid;
    logic               res_ready;
    logic [31:0]        result;
    logic               ovf;
    logic               busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pp_accumulator #(.ACC_W(42), .LEN_W(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .len_i          (len),
        .normal_mul_i   (normal_mul),
        .pp_valid_i     (pp_valid),
        .pp_ready_o     (pp_ready),
        .partial_prods_i(pp),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .result_o       (result),
        .ovf_o          (ovf),
        .busy_o         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pp(input logic signed [33:0] a, b, c, d);
        pp[0] = a; pp[1] = b; pp[2] = c; pp[3] = d;
    endtask

    task automatic do_start(input logic [7:0] l, input logic nm);
        start = 1'b1; len = l; normal_mul = nm;
        tick();
        start = 1'b0;
    endtask

    // Drives pp_valid until res_valid appears (bounded), counting accepted beats.
    task automatic feed(input bit toggle, output int beats, output int cycles);
        beats = 0; cycles = 0;
        while (!res_valid && cycles < 60) begin
            pp_valid = toggle ? (cycles % 2 == 0) : 1'b1;
            if (pp_valid && pp_ready) beats++;
            tick();
            cycles++;
        end
        pp_valid = 1'b0;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; normal_mul = 1'b0;
        pp_valid = 1'b0; res_ready = 1'b0; set_pp(0, 0, 0, 0);
        tick(); tick();
        total++;
        if ({pp_ready, res_valid, busy, ovf, result} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b ovf=%b res=%h want all 0",
                     pp_ready, res_valid, busy, ovf, result);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_beat();
        int b, c;
        do_start(8'd1, 1'b0);
        total++;
        if (pp_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_cycle1 got rdy=%b vld=%b busy=%b want 1 0 1", pp_ready, res_valid, busy);
        end
        set_pp(34'sd3, -34'sd5, 34'sd7, 34'sd10);
        feed(1'b0, b, c);
        total++;
        if (b !== 1 || c !== 1) begin
            bad++;
            $display("FAIL single_latency got beats=%0d cycles=%0d want 1 1", b, c);
        end
        total++;
        if (result !== 32'd15 || ovf !== 1'b0 || pp_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_result got res=%h ovf=%b rdy=%b want 0000000f 0 0", result, ovf, pp_ready);
        end
        accept();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got busy=%b vld=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_normal_mul();
        int b, c;
        do_start(8'd9, 1'b1);
        set_pp(34'h0_1234_5678, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF);
        feed(1'b0, b, c);
        total++;
        if (b !== 1) begin
            bad++;
            $display("FAIL normal_beats got %0d want 1", b);
        end
        total++;
        if (result !== 32'h1234_5678 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL normal_result got res=%h ovf=%b want 12345678 0", result, ovf);
        end
        accept();
    endtask

    task automatic test_multi_beat();
        int b, c;
        do_start(8'd4, 1'b0);
        set_pp(34'sd1, 34'sd1, 34'sd1, 34'sd1);
        feed(1'b1, b, c);
        total++;
        if (b !== 4 || c !== 7) begin
            bad++;
            $display("FAIL multi_beats got beats=%0d cycles=%0d want 4 7", b, c);
        end
        total++;
        if (result !== 32'd16 || pp_ready !== 1'b0 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL multi_result got res=%h rdy=%b vld=%b want 00000010 0 1", result, pp_ready, res_valid);
        end
        accept();
        do_start(8'd0, 1'b0);
        feed(1'b0, b, c);
        total++;
        if (b !== 1 || result !== 32'd4) begin
            bad++;
            $display("FAIL len0 got beats=%0d res=%h want 1 00000004", b, result);
        end
        accept();
    endtask

    task automatic test_overflow();
        int b, c;
        logic [31:0] exp_res;
`ifdef PP_ACC_SATURATE_EN
        exp_res = 32'h7FFF_FFFF;
`else
        exp_res = 32'hFFFF_FFF8;
`endif
        do_start(8'd2, 1'b0);
        set_pp(34'h0_7FFF_FFFF, 34'h0_7FFF_FFFF, 34'h0_7FFF_FFFF, 34'h0_7FFF_FFFF);
        feed(1'b0, b, c);
        total++;
        if (b !== 2 || ovf !== 1'b1 || result !== exp_res) begin
            bad++;
            $display("FAIL overflow got beats=%0d ovf=%b res=%h want 2 1 %h", b, ovf, result, exp_res);
        end
    endtask

    // Continues from the DONE state left by test_overflow.
    task automatic test_backpressure();
        logic [31:0] held;
        held = result;
        set_pp(34'sd100, 34'sd100, 34'sd100, 34'sd100);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; pp_valid = 1'b1; len = 8'd3;
            tick();
            total++;
            if (result !== held || ovf !== 1'b1 || res_valid !== 1'b1 || pp_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_%0d got res=%h ovf=%b vld=%b rdy=%b want %h 1 1 0",
                         i, result, ovf, res_valid, pp_ready, held);
            end
        end
        start = 1'b0; pp_valid = 1'b0;
        accept();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_release got busy=%b vld=%b want 0 0", busy, res_valid);
        end
        do_start(8'd1, 1'b0);
        total++;
        if (pp_ready !== 1'b1 || result !== 32'd0) begin
            bad++;
            $display("FAIL back_to_back got rdy=%b res=%h want 1 00000000", pp_ready, result);
        end
        set_pp(34'sd2, 34'sd2, -34'sd1, 34'sd0);
        pp_valid = 1'b1;
        tick();
        pp_valid = 1'b0;
        total++;
        if (res_valid !== 1'b1 || result !== 32'd3) begin
            bad++;
            $display("FAIL back_to_back_res got vld=%b res=%h want 1 00000003", res_valid, result);
        end
        accept();
    endtask

    task automatic test_reset_mid_op();
        int b, c;
        do_start(8'd4, 1'b0);
        set_pp(34'sd1, 34'sd1, 34'sd1, 34'sd1);
        pp_valid = 1'b1;
        tick(); tick();
        pp_valid = 1'b0;
        total++;
        if (result !== 32'd8 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_partial got res=%h busy=%b want 00000008 1", result, busy);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if ({pp_ready, res_valid, busy, ovf, result} !== 36'd0) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b vld=%b busy=%b ovf=%b res=%h want all 0",
                     pp_ready, res_valid, busy, ovf, result);
        end
        rst_n = 1'b1;
        do_start(8'd1, 1'b0);
        set_pp(34'sd1, 34'sd0, 34'sd0, 34'sd0);
        feed(1'b0, b, c);
        total++;
        if (b !== 1 || result !== 32'd1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got beats=%0d res=%h ovf=%b want 1 00000001 0", b, result, ovf);
        end
        accept();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_normal_mul();
        test_multi_beat();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
